// File: rtl/pdm_capture_ctrl.sv
// PDM capture session controller: mic wake-up, CIC settle discard, length-bounded sample delivery.
// Build option: define PDM_CAP_CONTINUOUS_EN so that a start with length == 0 captures until stop.
module pdm_capture_ctrl #(
   parameter int SAMPLE_W        = 16,
   parameter int LEN_W           = 16,
   parameter int WAKEUP_CYCLES   = 1_000_000,
   parameter int DISCARD_SAMPLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [LEN_W-1:0]    length,
   output logic                mic_en,
   output logic                cap_clr,
   input  logic [SAMPLE_W-1:0] pcm_in,
   input  logic                pcm_valid,
   output logic [SAMPLE_W-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [LEN_W-1:0]    count
);
   localparam int TMR_W  = (WAKEUP_CYCLES > 1) ? $clog2(WAKEUP_CYCLES) : 1;
   localparam int DISC_W = (DISCARD_SAMPLES > 1) ? $clog2(DISCARD_SAMPLES) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(WAKEUP_CYCLES - 1);
   localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'((DISCARD_SAMPLES > 0) ? DISCARD_SAMPLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_WAKEUP, S_SETTLE, S_CAPTURE, S_DRAIN, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q;
   logic [DISC_W-1:0]   disc_q;
   logic [LEN_W-1:0]    length_q;
   logic [LEN_W-1:0]    count_q;
   logic                overflow_q;
   logic                out_valid_q;
   logic [SAMPLE_W-1:0] out_data_q;
   logic                mic_en_q;
   logic                cap_clr_q;
   logic                busy_q;
   logic                done_q;

   logic                start_ok;
   logic                accept_start;
   logic                slot_free;
   logic                load;
   logic                last_load;
   logic [LEN_W-1:0]    count_inc;

`ifdef PDM_CAP_CONTINUOUS_EN
   assign start_ok = 1'b1;
`else
   assign start_ok = (length != '0);
`endif

   assign accept_start = start && start_ok && (state_q == S_IDLE || state_q == S_DONE);
   assign slot_free    = !out_valid_q || out_ready;
   assign load         = (state_q == S_CAPTURE) && pcm_valid && slot_free;
   assign count_inc    = (count_q == '1) ? count_q : count_q + 1'b1;
   // A latched length of zero (continuous mode) can never match, so capture only ends on stop.
   assign last_load    = load && (({1'b0, count_q} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, length_q});

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (accept_start) state_d = S_WAKEUP;
         S_WAKEUP: begin
            if (stop)                     state_d = S_IDLE;
            else if (timer_q == TMR_LAST) state_d = (DISCARD_SAMPLES == 0) ? S_CAPTURE : S_SETTLE;
         end
         S_SETTLE: begin
            if (stop)                                state_d = S_IDLE;
            else if (pcm_valid && disc_q == DISC_LAST) state_d = S_CAPTURE;
         end
         S_CAPTURE: if (stop || last_load) state_d = S_DRAIN;
         S_DRAIN:   if (slot_free)         state_d = S_DONE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         disc_q      <= '0;
         length_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         mic_en_q    <= 1'b0;
         cap_clr_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mic_en_q  <= state_d inside {S_WAKEUP, S_SETTLE, S_CAPTURE};
         busy_q    <= state_d inside {S_WAKEUP, S_SETTLE, S_CAPTURE, S_DRAIN};
         done_q    <= (state_d == S_DONE);
         cap_clr_q <= accept_start;
         timer_q   <= (state_q == S_WAKEUP) ? timer_q + 1'b1 : '0;

         if (state_q != S_SETTLE) disc_q <= '0;
         else if (pcm_valid)      disc_q <= disc_q + 1'b1;

         if (accept_start) begin
            length_q   <= length;
            count_q    <= '0;
            overflow_q <= 1'b0;
         end else if (state_q == S_CAPTURE && pcm_valid) begin
            if (slot_free) count_q    <= count_inc;
            else           overflow_q <= 1'b1;
         end

         if (load) begin
            out_data_q  <= pcm_in;
            out_valid_q <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign mic_en    = mic_en_q;
   assign cap_clr   = cap_clr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign count     = count_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Bench for pdm_capture_ctrl: directed sessions with literal checks, then random traffic
// compared every cycle against a session-level model.
module tb_pdm_capture_ctrl;
   localparam int SW   = 16;
   localparam int LW   = 6;
   localparam int WK   = 8;
   localparam int DS   = 2;
   localparam int MAXC = (1 << LW) - 1;
`ifdef PDM_CAP_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif
   localparam int P_IDLE = 0, P_WAKE = 1, P_SETTLE = 2, P_CAP = 3, P_DRAIN = 4, P_DONE = 5;

   logic          clk, rst, start, stop, pcm_valid, out_ready;
   logic [LW-1:0] length;
   logic [SW-1:0] pcm_in;
   logic          mic_en, cap_clr, out_valid, busy, done, overflow;
   logic [SW-1:0] out_data;
   logic [LW-1:0] count;

   pdm_capture_ctrl #(
      .SAMPLE_W(SW), .LEN_W(LW), .WAKEUP_CYCLES(WK), .DISCARD_SAMPLES(DS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .length(length),
      .mic_en(mic_en), .cap_clr(cap_clr), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .overflow(overflow), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Session model: countdowns for wake-up and discard, a one-entry slot, and the delivery tally.
   int m_phase = P_IDLE, m_wake_left = 0, m_disc_left = 0, m_count = 0, m_len = 0, m_val = 0;
   bit m_ovf = 0, m_clr = 0, m_full = 0, m_take, m_loaded;

   always @(posedge clk) begin
      m_take   = m_full && out_ready;
      m_loaded = 1'b0;
      if (rst) begin
         m_phase = P_IDLE; m_count = 0; m_ovf = 0; m_clr = 0; m_full = 0; m_val = 0;
      end else begin
         m_clr = 1'b0;
         case (m_phase)
            P_IDLE, P_DONE: if (start && (length != 0 || CONT)) begin
               m_len = int'(length); m_count = 0; m_ovf = 0; m_clr = 1'b1;
               m_wake_left = WK; m_phase = P_WAKE;
            end
            P_WAKE: if (stop) m_phase = P_IDLE;
            else begin
               m_wake_left--;
               if (m_wake_left == 0) begin
                  m_disc_left = DS;
                  m_phase = (DS == 0) ? P_CAP : P_SETTLE;
               end
            end
            P_SETTLE: if (stop) m_phase = P_IDLE;
            else if (pcm_valid) begin
               m_disc_left--;
               if (m_disc_left == 0) m_phase = P_CAP;
            end
            P_CAP: begin
               if (pcm_valid) begin
                  if (!m_full || m_take) begin
                     m_val = int'(pcm_in); m_loaded = 1'b1;
                     if (m_count < MAXC) m_count++;
                     if (m_len != 0 && m_count == m_len) m_phase = P_DRAIN;
                  end else m_ovf = 1'b1;
               end
               if (stop) m_phase = P_DRAIN;
            end
            P_DRAIN: if (!m_full || m_take) m_phase = P_DONE;
            default: m_phase = P_IDLE;
         endcase
         if (m_loaded)    m_full = 1'b1;
         else if (m_take) m_full = 1'b0;
      end
   end

   int delivered[$];
   always @(posedge clk) if (!rst && out_valid && out_ready) delivered.push_back(int'(out_data));

   always @(negedge clk) if (chk_en) begin
      chk("mic_en", mic_en, (m_phase == P_WAKE || m_phase == P_SETTLE || m_phase == P_CAP));
      chk("busy", busy, (m_phase >= P_WAKE && m_phase <= P_DRAIN));
      chk("done", done, (m_phase == P_DONE));
      chk("cap_clr", cap_clr, m_clr);
      chk("overflow", overflow, m_ovf);
      chk("count", count, m_count);
      chk("out_valid", out_valid, m_full);
      if (m_full) chk("out_data", out_data, m_val);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic strobe(input int v);
      pcm_in = SW'(v); pcm_valid = 1'b1; cyc(1);
      pcm_valid = 1'b0; cyc(3);
   endtask

   task automatic begin_session(input int len, input bit rdy);
      delivered.delete();
      length = LW'(len); out_ready = rdy; start = 1'b1; cyc(1);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; length = '0; pcm_in = '0; pcm_valid = 1'b0; out_ready = 1'b1;
      cyc(3);
      chk_en = 1'b1;
      chk("rst_busy", busy, 0); chk("rst_mic", mic_en, 0); chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0); chk("rst_count", count, 0); chk("rst_done", done, 0);
      rst = 1'b0; cyc(2);

      // Basic session, sink always ready.
      begin_session(3, 1'b1);
      chk("t1_mic_rise", mic_en, 1); chk("t1_clr", cap_clr, 1);
      cyc(1); chk("t1_clr_once", cap_clr, 0);
      cyc(10);
      for (int v = 1; v <= 6; v++) strobe(v);
      cyc(4);
      chk("t1_done", done, 1); chk("t1_count", count, 3); chk("t1_ovf", overflow, 0); chk("t1_mic", mic_en, 0);
      chk("t1_ndeliv", delivered.size(), 3);
      if (delivered.size() == 3) begin
         chk("t1_d0", delivered[0], 3); chk("t1_d1", delivered[1], 4); chk("t1_d2", delivered[2], 5);
      end

      // Back-pressure: first sample held, second dropped.
      begin_session(3, 1'b0);
      cyc(11);
      for (int v = 1; v <= 4; v++) strobe(v);
      chk("t2_ovf", overflow, 1); chk("t2_valid", out_valid, 1); chk("t2_data", out_data, 3); chk("t2_count", count, 1);
      out_ready = 1'b1;
      for (int v = 5; v <= 8; v++) strobe(v);
      cyc(4);
      chk("t2_done", done, 1); chk("t2_count_end", count, 3); chk("t2_ndeliv", delivered.size(), 3);
      if (delivered.size() == 3) begin
         chk("t2_d1", delivered[1], 5); chk("t2_d2", delivered[2], 6);
      end

      // Restart from DONE with overflow set.
      chk("t6_ovf_before", overflow, 1);
      begin_session(2, 1'b1);
      chk("t6_ovf_clr", overflow, 0); chk("t6_count_clr", count, 0); chk("t6_clr", cap_clr, 1); chk("t6_done", done, 0);
      cyc(11);
      for (int v = 1; v <= 5; v++) strobe(v);
      cyc(4);
      chk("t6_done_end", done, 1); chk("t6_count", count, 2); chk("t6_ovf_end", overflow, 0);

      // Stop during wake-up.
      begin_session(3, 1'b1);
      cyc(2); stop = 1'b1; cyc(1); stop = 1'b0;
      chk("t3_mic", mic_en, 0); chk("t3_done", done, 0); chk("t3_busy", busy, 0);
      for (int v = 1; v <= 4; v++) strobe(v);
      chk("t3_valid", out_valid, 0); chk("t3_busy_end", busy, 0);

      // Stop during capture with a sample pending and the sink stalled.
      begin_session(5, 1'b0);
      cyc(11);
      for (int v = 1; v <= 3; v++) strobe(v);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("t4_busy", busy, 1); chk("t4_mic", mic_en, 0); chk("t4_valid", out_valid, 1); chk("t4_data", out_data, 3);
      cyc(3); chk("t4_done_wait", done, 0);
      out_ready = 1'b1; cyc(1);
      chk("t4_done", done, 1); chk("t4_valid_end", out_valid, 0); chk("t4_count", count, 1);

      // Reset in the middle of capture.
      begin_session(5, 1'b0);
      cyc(11);
      for (int v = 1; v <= 3; v++) strobe(v);
      chk("t5_valid_pre", out_valid, 1);
      rst = 1'b1; cyc(1);
      chk("t5_mic", mic_en, 0); chk("t5_busy", busy, 0); chk("t5_valid", out_valid, 0); chk("t5_data", out_data, 0);
      chk("t5_count", count, 0); chk("t5_done", done, 0); chk("t5_ovf", overflow, 0); chk("t5_clr", cap_clr, 0);
      rst = 1'b0; cyc(1);

      // Zero-length start.
      begin_session(0, 1'b1);
`ifdef PDM_CAP_CONTINUOUS_EN
      chk("t7_busy", busy, 1); chk("t7_clr", cap_clr, 1);
      cyc(10);
      for (int v = 1; v <= 6; v++) strobe(v);
      chk("t7_still_busy", busy, 1);
      stop = 1'b1; cyc(1); stop = 1'b0; cyc(3);
      chk("t7_done", done, 1); chk("t7_count", count, 4);
`else
      chk("t7_busy", busy, 0); chk("t7_clr", cap_clr, 0); chk("t7_mic", mic_en, 0);
      cyc(3); chk("t7_busy_later", busy, 0);
`endif

      // Maximum length, one sample per cycle with load and handshake coinciding.
      begin_session(MAXC, 1'b1);
      cyc(11);
      for (int i = 0; i < 70; i++) begin
         pcm_in = SW'(i + 100); pcm_valid = 1'b1; cyc(1);
      end
      pcm_valid = 1'b0; cyc(3);
      chk("tmax_count", count, MAXC); chk("tmax_done", done, 1); chk("tmax_ovf", overflow, 0);
      chk("tmax_ndeliv", delivered.size(), MAXC);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom % 700) == 0;
         start     = ($urandom % 20) == 0;
         length    = LW'($urandom_range(0, 8));
         stop      = ($urandom % 80) == 0;
         pcm_valid = ($urandom % 3) == 0;
         pcm_in    = SW'($urandom);
         out_ready = ($urandom % 4) != 0;
         cyc(1);
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0; pcm_valid = 1'b0; out_ready = 1'b1;
      cyc(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
